// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared state encodings, limits and tag-width helper
package adder_arbiter_pkg;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  localparam int MAX_REQ = 4;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adder.sv
// adder: the CPU's shared combinational adder
module adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

// File: rtl/adder_arbiter_rr.sv
// rr_arbiter: round-robin grant search starting after last_grant
module rr_arbiter #(
  parameter int N = 2,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic            en_i,
  input  logic            advance_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o
);
  logic [ID_W-1:0] last_q;
  logic [N-1:0] oh;
  int best;
  // smallest rotated distance from last_q+1 wins
  always_comb begin
    idx_o = last_q;
    oh = '0;
    best = N;
    for (int i = 0; i < N; i++)
      if (req_i[i] && ((i - int'(last_q) - 1 + N) % N) < best) begin
        best = (i - int'(last_q) - 1 + N) % N;
        idx_o = ID_W'(i);
        oh = '0;
        oh[i] = 1'b1;
      end
    gnt_o = en_i ? oh : '0;
  end
  always_ff @(posedge clk)
    if (rst) last_q <= ID_W'(N - 1);
    else if (advance_i) last_q <= idx_o;
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder with a registered, tagged response
module adder_arbiter import adder_arbiter_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH = 16,
  parameter int ID_W = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_ovf
);
  logic [0:0] state_q, state_d;
  logic [ID_W-1:0] idx, id_q;
  logic [WIDTH-1:0] a, b, sum, res_q;
  logic carry, ovf, carry_q, ovf_q, can_issue, grant;
  assign can_issue = (state_q == EMPTY) || rsp_ready;
  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .clk(clk), .rst(rst), .req_i(req_valid), .en_i(can_issue && !rst),
    .advance_i(grant), .gnt_o(req_ready), .idx_o(idx)
  );
  assign grant = |req_ready;
  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) begin
        a = req_a[i*WIDTH +: WIDTH];
        b = req_b[i*WIDTH +: WIDTH];
      end
  end
  adder #(.WIDTH(WIDTH)) u_adder (.a_i(a), .b_i(b), .sum_o(sum));
  assign carry = sum < a;
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  always_comb state_d = grant ? FULL : (rsp_ready ? EMPTY : state_q);
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= EMPTY;
      id_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q <= idx;
        res_q <= sum;
        carry_q <= carry;
        ovf_q <= ovf;
      end
    end
  assign rsp_valid = state_q == FULL;
  assign rsp_id = id_q;
  assign rsp_result = res_q;
  assign rsp_carry = carry_q;
  assign rsp_ovf = ovf_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: table-driven directed checks of the two-requester arbiter
module tb_adder_arbiter;
  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b0;
  logic [1:0] req_valid = '0, req_ready;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, rsp_result;
  logic rsp_valid, rsp_carry, rsp_ovf;
  logic [0:0] rsp_id;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  adder_arbiter #(.NUM_REQ(2), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a({a1, a0}), .req_b({b1, b0}),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf)
  );
  typedef struct {
    logic [1:0] v;
    logic [15:0] a0, b0, a1, b1;
    logic rr;
    logic [1:0] er;
    logic ev, eid;
    logic [15:0] eres;
    logic ec, eo;
  } vec_t;
  vec_t tv[15];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  initial begin
    tv[0]  = '{2'b11, 16'd1, 16'd2, 16'd20, 16'hFFF6, 1'b1, 2'b01, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0};
    tv[1]  = '{2'b10, 16'd1, 16'd2, 16'd20, 16'hFFF6, 1'b1, 2'b10, 1'b1, 1'b1, 16'd10, 1'b1, 1'b0};
    tv[2]  = '{2'b11, 16'd13000, 16'd20000, 16'd42000, 16'd30000, 1'b1, 2'b01, 1'b1, 1'b0, 16'd33000, 1'b0, 1'b1};
    tv[3]  = '{2'b11, 16'd13000, 16'd20000, 16'd42000, 16'd30000, 1'b1, 2'b10, 1'b1, 1'b1, 16'd6464, 1'b1, 1'b0};
    tv[4]  = '{2'b11, 16'd13000, 16'd20000, 16'd42000, 16'd30000, 1'b1, 2'b01, 1'b1, 1'b0, 16'd33000, 1'b0, 1'b1};
    tv[5]  = '{2'b11, 16'd13000, 16'd20000, 16'd42000, 16'd30000, 1'b1, 2'b10, 1'b1, 1'b1, 16'd6464, 1'b1, 1'b0};
    tv[6]  = '{2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 2'b00, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tv[7]  = '{2'b01, 16'd100, 16'd200, 16'd0, 16'd0, 1'b0, 2'b01, 1'b1, 1'b0, 16'd300, 1'b0, 1'b0};
    tv[8]  = '{2'b11, 16'd5, 16'd6, 16'd7, 16'd8, 1'b0, 2'b00, 1'b1, 1'b0, 16'd300, 1'b0, 1'b0};
    tv[9]  = '{2'b11, 16'd5, 16'd6, 16'd7, 16'd8, 1'b0, 2'b00, 1'b1, 1'b0, 16'd300, 1'b0, 1'b0};
    tv[10] = '{2'b11, 16'd5, 16'd6, 16'd7, 16'd8, 1'b0, 2'b00, 1'b1, 1'b0, 16'd300, 1'b0, 1'b0};
    tv[11] = '{2'b11, 16'd5, 16'd6, 16'd7, 16'd8, 1'b1, 2'b10, 1'b1, 1'b1, 16'd15, 1'b0, 1'b0};
    tv[12] = '{2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 2'b00, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tv[13] = '{2'b10, 16'd0, 16'd0, 16'hFFFF, 16'd1, 1'b1, 2'b10, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0};
    tv[14] = '{2'b01, 16'h8000, 16'h8000, 16'd0, 16'd0, 1'b1, 2'b01, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1};
    req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_result", 32'(rsp_result), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      req_valid = tv[i].v; a0 = tv[i].a0; b0 = tv[i].b0;
      a1 = tv[i].a1; b1 = tv[i].b1; rsp_ready = tv[i].rr;
      #1 check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tv[i].er));
      @(posedge clk);
      #1 check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        check($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(tv[i].eid));
        check($sformatf("v%0d rsp_result", i), 32'(rsp_result), 32'(tv[i].eres));
        check($sformatf("v%0d rsp_carry", i), 32'(rsp_carry), 32'(tv[i].ec));
        check($sformatf("v%0d rsp_ovf", i), 32'(rsp_ovf), 32'(tv[i].eo));
      end
      @(negedge clk);
    end
    // reset while FULL with a pending request: result must be discarded
    req_valid = 2'b01; a0 = 16'h1234; b0 = 16'd1; rsp_ready = 1'b0; rst = 1'b1;
    #1 check("midrst req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst rsp_result", 32'(rsp_result), 32'd0);
    check("midrst rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    @(posedge clk);
    #1 check("postrst rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 2'b11; a1 = 16'd9; b1 = 16'd9;
    #1 check("postrst first grant", 32'(req_ready), 32'b01);
    @(posedge clk);
    #1 check("postrst rsp_id", 32'(rsp_id), 32'd0);
    check("postrst rsp_result", 32'(rsp_result), 32'h1235);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
